// File: rtl/rip_nr1w_bram_pkg.sv
// ---------------------------------------------------------------------------
// rip_const
//
// Purpose:
//   Shared constants and types for the rip memory primitives.
//
// Contents:
//   B_WIDTH       - width of one byte lane.
//   bram_state_e  - controller states of the N-read/1-write BRAM
//                   (CLEAR while the post-reset zeroing runs, RUN after).
//   num_lanes()   - number of byte lanes in a word of a given width.
// ---------------------------------------------------------------------------
package rip_const;

    localparam int B_WIDTH = 8;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } bram_state_e;

    function automatic int num_lanes(input int data_width);
        return data_width / B_WIDTH;
    endfunction

endpackage

// File: rtl/rip_nr1w_bram_bank.sv
// ---------------------------------------------------------------------------
// rip_1r1w_bram_bank
//
// Purpose:
//   One replicated bank of the N-read/1-write BRAM: a single synchronous
//   read port and a single byte-lane-enabled write port.  A read that hits
//   the address being written in the same cycle returns the OLD word; the
//   top level patches in the new lanes afterwards.  No reset: the array and
//   the read latch power up undefined.
//
// Ports:
//   clk    - rising-edge clock
//   we     - per-lane write enables
//   waddr  - write address
//   wdata  - write data
//   ren    - read enable; rdata holds when low
//   raddr  - read address
//   rdata  - registered read data
// ---------------------------------------------------------------------------
module rip_1r1w_bram_bank
    import rip_const::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NB         = DATA_WIDTH / B_WIDTH
) (
    input  logic                  clk,
    input  logic [NB-1:0]         we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Lane-wise write so the tools map it onto the BRAM byte-write enables.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                r_mem[waddr][b*B_WIDTH +: B_WIDTH] <= wdata[b*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // Synchronous read, read-old-data on collision; the latch holds when idle.
    always_ff @(posedge clk) begin
        if (ren) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

// File: rtl/rip_nr1w_bram.sv
// ---------------------------------------------------------------------------
// rip_nr1w_bram
//
// Purpose:
//   Parametrised N-read/1-write block RAM.  Every read port owns a private
//   bank; the single write port updates all banks in lock-step.  Provides
//   byte-lane write enables, write-first behaviour on same-cycle
//   read/write address collisions, an optional output pipeline stage and a
//   post-reset sequencer that zeroes every word before the block goes ready.
//
// Parameters:
//   DATA_WIDTH      - word width (multiple of B_WIDTH)
//   ADDR_WIDTH      - depth is 2**ADDR_WIDTH words
//   NUM_RD          - number of read ports (1..8)
//   OUT_REG         - 1 adds one output pipeline stage
//   CLEAR_ON_RESET  - 1 zeroes the array after reset
//
// Ports:
//   clk, rstn       - clock (rising) and asynchronous active-low reset
//   ready           - block accepts reads and writes
//   wr_en, wr_be,
//   wr_addr, wr_data- write port with per-lane enables
//   rd_en, rd_addr  - per-port read requests (port i: slice i)
//   rd_data,
//   rd_valid        - per-port read data and one-cycle valid strobe
// ---------------------------------------------------------------------------
module rip_nr1w_bram
    import rip_const::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int NUM_RD         = 2,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    output logic                         ready,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH/B_WIDTH-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid
);

    localparam int NB = num_lanes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam bram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic RESET_READY = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

    bram_state_e           r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_ready;

    logic                  w_clearing;
    logic                  w_user_wr;
    logic [NB-1:0]         w_bank_we;
    logic [ADDR_WIDTH-1:0] w_bank_waddr;
    logic [DATA_WIDTH-1:0] w_bank_wdata;
    logic [DATA_WIDTH-1:0] w_wr_mask;

    // Clear sequencer.  ready is registered from the state, so it rises one
    // edge after the FSM enters RUN.  clr_addr parks on the last address
    // instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= RESET_STATE;
            r_clr_addr <= '0;
            r_ready    <= RESET_READY;
        end else begin
            r_ready <= (r_state == RUN);
            case (r_state)
                CLEAR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= RUN;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                RUN:     r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    assign ready = r_ready;

    // Write mux: the clear sequencer owns the banks while clearing; user
    // writes only commit once ready.
    assign w_clearing   = (r_state == CLEAR);
    assign w_user_wr    = wr_en && r_ready;
    assign w_bank_we    = w_clearing ? {NB{1'b1}} : (w_user_wr ? wr_be : '0);
    assign w_bank_waddr = w_clearing ? r_clr_addr : wr_addr;
    assign w_bank_wdata = w_clearing ? '0 : wr_data;

    // Bit mask of the lanes a user write touches, used by the bypass merge.
    always_comb begin
        w_wr_mask = '0;
        for (int b = 0; b < NB; b++) begin
            w_wr_mask[b*B_WIDTH +: B_WIDTH] = {B_WIDTH{wr_be[b]}};
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic                  w_acc;
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] w_bank_rdata;
        logic [DATA_WIDTH-1:0] w_merged;
        logic [DATA_WIDTH-1:0] r_byp_mask;
        logic [DATA_WIDTH-1:0] r_byp_data;
        logic                  r_vld1;

        assign w_raddr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_acc   = rd_en[i] && r_ready;
        assign w_hit   = w_acc && w_user_wr && (w_raddr == wr_addr);

        rip_1r1w_bram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NB         (NB)
        ) u_bank (
            .clk   (clk),
            .we    (w_bank_we),
            .waddr (w_bank_waddr),
            .wdata (w_bank_wdata),
            .ren   (w_acc),
            .raddr (w_raddr),
            .rdata (w_bank_rdata)
        );

        // Bypass capture.  The hit flag is folded into the lane mask (all
        // zero on a miss).  Updated only on an accepted read so the merged
        // word stays stable alongside the held bank latch between reads.
        always_ff @(posedge clk) begin
            if (w_acc) begin
                r_byp_mask <= w_hit ? w_wr_mask : '0;
                r_byp_data <= wr_data;
            end
        end

        // Write-first merge after the BRAM read: new lanes over old word.
        assign w_merged = (w_bank_rdata & ~r_byp_mask) | (r_byp_data & r_byp_mask);

        // First valid stage; reset kills any read in flight.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_vld1 <= 1'b0;
            end else begin
                r_vld1 <= w_acc;
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic                  r_vld2;
            logic [DATA_WIDTH-1:0] r_out;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_vld2 <= 1'b0;
                end else begin
                    r_vld2 <= r_vld1;
                end
            end

            // Output stage loads only with valid data so it holds otherwise.
            always_ff @(posedge clk) begin
                if (r_vld1) begin
                    r_out <= w_merged;
                end
            end

            assign rd_valid[i]                       = r_vld2;
            assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_out;
        end else begin : g_noreg
            assign rd_valid[i]                       = r_vld1;
            assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_merged;
        end
    end

endmodule

// File: tb/tb_rip_nr1w_bram.sv
// ---------------------------------------------------------------------------
// tb_rip_nr1w_bram
//
// Two instances share one stimulus stream: u_dut0 without and u_dut1 with
// the output register.  A behavioural memory model (plain array, write
// applied before read) predicts every read; the DUT0 result appears one
// edge after the request, the DUT1 result two edges after.
// ---------------------------------------------------------------------------
module tb_rip_nr1w_bram;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NR    = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            wr_en;
    logic [NB-1:0]   wr_be;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NR-1:0]   rd_en;
    logic [NR*AW-1:0] rd_addr;

    logic            ready0, ready1;
    logic [NR*DW-1:0] rd_data0, rd_data1;
    logic [NR-1:0]   rd_valid0, rd_valid1;

    always #5 clk = ~clk;

    rip_nr1w_bram #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_RD (NR),
        .OUT_REG (0), .CLEAR_ON_RESET (1)
    ) u_dut0 (
        .clk (clk), .rstn (rstn), .ready (ready0),
        .wr_en (wr_en), .wr_be (wr_be), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (rd_data0), .rd_valid (rd_valid0)
    );

    rip_nr1w_bram #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_RD (NR),
        .OUT_REG (1), .CLEAR_ON_RESET (1)
    ) u_dut1 (
        .clk (clk), .rstn (rstn), .ready (ready1),
        .wr_en (wr_en), .wr_be (wr_be), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (rd_data1), .rd_valid (rd_valid1)
    );

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt;
    logic          m_ready;
    logic [NR-1:0] e0_v, e1_v;
    logic [DW-1:0] e0_d [NR];
    logic [DW-1:0] e1_d [NR];

    int nvec;
    int nmis;

    typedef struct {
        logic          wen;
        logic [NB-1:0] be;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [NR-1:0] ren;
        logic [NR*AW-1:0] raddr;
        logic [NR-1:0] xv;
        logic [NR*DW-1:0] xd;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_be   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
    endtask

    // Reset wipes the model: the clear sequence zeroes the whole array
    // before any read can be accepted.
    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        m_cnt   = 0;
        m_ready = 1'b0;
        e0_v    = '0;
        e1_v    = '0;
    endtask

    task automatic checkOutput();
        chk("ready0", 32'(ready0), 32'(m_ready));
        chk("ready1", 32'(ready1), 32'(m_ready));
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("valid0[%0d]", i), 32'(rd_valid0[i]), 32'(e0_v[i]));
            if (e0_v[i]) chk($sformatf("data0[%0d]", i), rd_data0[i*DW +: DW], e0_d[i]);
            chk($sformatf("valid1[%0d]", i), 32'(rd_valid1[i]), 32'(e1_v[i]));
            if (e1_v[i]) chk($sformatf("data1[%0d]", i), rd_data1[i*DW +: DW], e1_d[i]);
        end
    endtask

    // One clock edge with the currently driven inputs, model update, check.
    task automatic applyStimulus();
        logic [NR-1:0] nv;
        logic [DW-1:0] nd [NR];
        if (wr_en && m_ready) begin
            for (int b = 0; b < NB; b++)
                if (wr_be[b]) m_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
        end
        for (int i = 0; i < NR; i++) begin
            nv[i] = rd_en[i] && m_ready;
            nd[i] = m_mem[rd_addr[i*AW +: AW]];
        end
        e1_v = e0_v;
        e1_d = e0_d;
        e0_v = nv;
        e0_d = nd;
        @(posedge clk);
        #1;
        if (m_cnt < DEPTH + 1) m_cnt++;
        m_ready = (m_cnt >= DEPTH + 1);
        checkOutput();
    endtask

    initial begin
        int first;
        nvec = 0;
        nmis = 0;
        idle();
        model_reset();

        vt[0]  = '{1'b1, 4'hF, 4'd3,  32'hAABBCCDD, 4'h0, 16'h0000, 4'h0, '0};
        vt[1]  = '{1'b1, 4'h5, 4'd3,  32'h11223344, 4'h0, 16'h0000, 4'h0, '0};
        vt[2]  = '{1'b0, 4'h0, 4'd0,  32'h0,        4'h1, 16'h0003, 4'h1,
                   {96'h0, 32'hAA22CC44}};
        vt[3]  = '{1'b1, 4'hC, 4'd7,  32'hDEADBEEF, 4'h2, 16'h0070, 4'h2,
                   {64'h0, 32'hDEAD0000, 32'h0}};
        vt[4]  = '{1'b1, 4'hF, 4'd8,  32'h08080808, 4'h0, 16'h0000, 4'h0, '0};
        vt[5]  = '{1'b1, 4'hF, 4'd9,  32'h09090909, 4'h0, 16'h0000, 4'h0, '0};
        vt[6]  = '{1'b1, 4'hF, 4'd10, 32'h0A0A0A0A, 4'h0, 16'h0000, 4'h0, '0};
        vt[7]  = '{1'b1, 4'hF, 4'd11, 32'h0B0B0B0B, 4'h0, 16'h0000, 4'h0, '0};
        vt[8]  = '{1'b0, 4'h0, 4'd0,  32'h0,        4'hF, 16'hBA98, 4'hF,
                   {32'h0B0B0B0B, 32'h0A0A0A0A, 32'h09090909, 32'h08080808}};
        vt[9]  = '{1'b1, 4'h0, 4'd3,  32'hFFFFFFFF, 4'hF, 16'h3333, 4'hF,
                   {32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44}};
        vt[10] = '{1'b1, 4'h2, 4'd5,  32'h1234EE78, 4'hC, 16'h7500, 4'hC,
                   {32'hDEAD0000, 32'h0000EE00, 64'h0}};

        // Reset state
        #12;
        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_ready1", 32'(ready1), 32'd0);
        chk("rst_valid0", 32'(rd_valid0), 32'd0);
        chk("rst_valid1", 32'(rd_valid1), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Clear timing, with a write and reads attempted mid-clear
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                wr_en = 1'b1; wr_be = 4'hF; wr_addr = 4'd2; wr_data = 32'h55;
                rd_en = 4'hF; rd_addr = 16'h2222;
            end else begin
                idle();
            end
            applyStimulus();
            if (ready0 && first == 0) first = k;
        end
        chk("clear_edges", 32'(first), 32'd17);

        // Gated write left no trace; cleared word reads zero
        idle();
        rd_en = 4'h3; rd_addr = 16'h0052;
        applyStimulus();
        chk("gated_wr_addr2", rd_data0[0 +: DW], 32'h0);
        chk("clear_addr5", rd_data0[DW +: DW], 32'h0);

        // Table vectors
        for (int v = 0; v < 11; v++) begin
            wr_en = vt[v].wen; wr_be = vt[v].be; wr_addr = vt[v].waddr;
            wr_data = vt[v].wdata; rd_en = vt[v].ren; rd_addr = vt[v].raddr;
            applyStimulus();
            chk($sformatf("vec%0d_valid", v), 32'(rd_valid0), 32'(vt[v].xv));
            for (int i = 0; i < NR; i++)
                if (vt[v].xv[i])
                    chk($sformatf("vec%0d_data[%0d]", v, i), rd_data0[i*DW +: DW], vt[v].xd[i*DW +: DW]);
        end
        idle();
        applyStimulus();

        // Reset while a read is in flight kills the strobes at once
        rd_en = 4'h1; rd_addr = 16'h0003;
        applyStimulus();
        idle();
        #1;
        rstn = 1'b0;
        #1;
        chk("kill_valid0", 32'(rd_valid0), 32'd0);
        chk("kill_valid1", 32'(rd_valid1), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // Reset pulsed at clear cycle 9 restarts the full clear
        for (int k = 0; k < 9; k++) applyStimulus();
        #2;
        rstn = 1'b0;
        #2;
        model_reset();
        rstn = 1'b1;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus();
            if (ready0 && first == 0) first = k;
        end
        chk("reclear_edges", 32'(first), 32'd17);

        // Randomised traffic over a small address space for frequent hits
        for (int n = 0; n < 400; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_be   = 4'($urandom);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_en   = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 3) == 0) rd_addr[i*AW +: AW] = wr_addr;
                else rd_addr[i*AW +: AW] = 4'($urandom_range(0, 15));
            end
            applyStimulus();
        end
        idle();
        for (int k = 0; k < 3; k++) applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/rip_nr1w_bram.md
# rip_nr1w_bram

Parametrised N-read / 1-write block RAM with byte-lane write enables, write-first bypass on same-address collisions, an optional output pipeline register, and a post-reset clear sequencer. It generalises the core's 2-read 1-write BRAM so that the register file, the CSR shadow store and the reservoir weight store can share one primitive. Each read port owns a replicated bank that the common write port updates in lock-step.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of `B_WIDTH`.
- `ADDR_WIDTH`, 10: depth is `2**ADDR_WIDTH` words.
- `NUM_RD`, 2: number of read ports, 1..8.
- `OUT_REG`, 0: 1 adds one output pipeline stage.
- `CLEAR_ON_RESET`, 1: 1 zeroes every word after reset.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `ready` output 1: block accepts reads and writes.
- `wr_en` input 1: write request.
- `wr_be` input `DATA_WIDTH/B_WIDTH`: byte-lane write enables.
- `wr_addr` input `ADDR_WIDTH`: write address.
- `wr_data` input `DATA_WIDTH`: write data.
- `rd_en` input `NUM_RD`: per-port read request.
- `rd_addr` input `NUM_RD*ADDR_WIDTH`: port `i` uses slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `rd_data` output `NUM_RD*DATA_WIDTH`: port `i` uses slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `rd_valid` output `NUM_RD`: per-port data-valid strobe.

## Operation
- Controller states are `CLEAR` and `RUN`.
  - On `rstn` low: state becomes `CLEAR` if `CLEAR_ON_RESET`=1, otherwise `RUN`. `clr_addr` resets to 0.
  - `CLEAR`: each cycle writes all-zero, all lanes, to `clr_addr` in every bank, then increments `clr_addr`. After writing address `2**ADDR_WIDTH-1`, the next state is `RUN`. `clr_addr` never wraps.
  - `RUN`: terminal state; only reset leaves it.
- `ready` = (state == `RUN`), registered.
- Write rules:
  - Write commits when `wr_en && ready`.
  - Lane `b` is written only if `wr_be[b]`; other lanes keep their old value.
  - `wr_be` = 0 is a legal no-op.
- Read rules:
  - A read is accepted when `rd_en[i] && ready`.
  - Requests while `ready`=0 are dropped and produce no `rd_valid`.
- Write-first bypass:
  - Applies when a read on port `i` and a committed write share the same address in the same cycle.
  - The returned word takes the new data on lanes with `wr_be` set and the old data on all other lanes.
  - Implementation: register the hit flag, `wr_be` and `wr_data`, then merge after the BRAM read. Do not use a combinational BRAM path.
- Ports are independent. Any number of ports may read the same address in one cycle.

## Timing
- Read issued at edge t: `rd_valid[i]` and data appear after edge t+1 (`OUT_REG`=0) or edge t+2 (`OUT_REG`=1), for one cycle.
- Throughput is one read per port per cycle. There is no backpressure.
- A write at edge t is visible to a read issued at edge t (through the bypass) and at every later edge.
- Output data holds its last value when `rd_valid` is low.
- Reset values:
  - `ready` = 0 if `CLEAR_ON_RESET`=1, else 1.
  - `rd_valid` = 0.
  - `rd_data` has no reset (BRAM output latch); it is undefined until the first `rd_valid`.
  - Array contents are not reset.
- Clear time: `ready` rises `2**ADDR_WIDTH`+1 edges after `rstn` deasserts.
- Reset asserted mid-clear or mid-read:
  - In-flight `rd_valid` is killed immediately.
  - `clr_addr` returns to 0 and the clear restarts from 0.

## Structure
- `B_WIDTH` comes from `rip_const`.
- Add `rip_const::bram_state_e` (`CLEAR`, `RUN`) to the shared package.
- Sub-module `rip_1r1w_bram_bank`:
  - One bank, instantiated `NUM_RD` times in a generate loop.
  - Ports: clk, we lanes, waddr, wdata, ren, raddr, rdata.
  - `ram_style = "block"`.
  - Contains no reset.
- The top level holds the clear FSM, the write mux (clear vs user), the bypass registers, the optional output stage and the valid pipeline.

## Test plan
- Clear on reset: `ADDR_WIDTH`=4, release `rstn` → `ready` low for 16 edges and high on the 17th. A read of address 5 then returns 0x00000000 with `rd_valid`.
- Byte-lane merge: write 0xAABBCCDD to address 3 with all lanes, then write 0x11223344 with `wr_be`=4'b0101 → a read of address 3 returns 0xAA22CC44.
- Bypass: address 7 holds 0x0; in the same cycle write 0xDEADBEEF with `wr_be`=4'b1100 and read port 1 at address 7 → port 1 returns 0xDEAD0000 one cycle later (two with `OUT_REG`=1).
- Multi-port: `NUM_RD`=4, all ports read different addresses holding known patterns in the same cycle → all four `rd_valid` assert together with the correct words.
- Gating during clear: assert `wr_en` (address 2, 0x55) and `rd_en` while `ready`=0 → no `rd_valid`, and address 2 reads 0 after `ready`.
- Mid-clear reset: pulse `rstn` low at clear cycle 9 → the clear restarts and `ready` rises 17 edges after the second deassertion. A pending `rd_valid` is cleared asynchronously.
